serv_mdu_iter: RTL
==================

Name: serv_mdu_iter

Overview:
Iterative RV32M multiply/divide unit. It is the responder on the CPU extension interface: the core drives rs1, rs2, funct3 and valid, and this block returns rd with a ready pulse. It sits beside serv_top in the rf-top level, with its rd ORed into the shared extension-result path. It uses a radix-2 shift-add/restoring-subtract datapath with fixed latency for every op.

Parameters:
DIV, 1, 1: divide/remainder ops implemented; 0: funct3[2]=1 ops return 0x00000000 with identical latency and handshake.
ZERO_RD, 1, 1: o_mdu_rd forced to 0 whenever o_mdu_ready=0 (safe for OR-bus); 0: o_mdu_rd holds the last result.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_mdu_valid  in  1  request; level, held by core until ready pulse
i_mdu_rs1  in  32  operand A (dividend / multiplicand); stable while valid
i_mdu_rs2  in  32  operand B (divisor / multiplier); stable while valid
i_mdu_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
o_mdu_rd  out  32  result; valid only in ready cycle
o_mdu_ready  out  1  single-cycle completion pulse

Behaviour:
- Reset (async assert, sync-safe deassert inside, no extra synchroniser): state=IDLE, counter=0, o_mdu_ready=0, o_mdu_rd=0. Datapath registers need not be reset.
- FSM: IDLE -> CALC -> FIX -> RESP -> GUARD -> IDLE.
- IDLE: valid sampled high at cycle 0 latches op, operand magnitudes, operand sign flags, zero flag (rs2==0) and overflow flag (rs1=0x80000000 & rs2=0xFFFFFFFF, signed div). Counter clears and state goes to CALC.
- CALC: cycles 1..32, one iteration per cycle. Counter is 5 bits and wraps 31->0 as it exits to FIX.
  - Multiply: 64-bit accumulator/shift register on unsigned magnitudes.
  - Divide: restoring on unsigned magnitudes with a 33-bit partial remainder.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- FIX (cycle 33): sign correction and special cases.
  - Product is negated if the operand signs differ. MUL takes the low 32 bits; MULH* take the high 32 bits.
  - Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
  - Divide-by-zero: quotient 0xFFFFFFFF (signed and unsigned), remainder = rs1.
  - Overflow: quotient 0x80000000, remainder 0.
- RESP (cycle 34): o_mdu_ready=1 for exactly one cycle, o_mdu_rd=result. Fixed latency: ready appears 34 cycles after the accept edge, for all ops including special cases.
- GUARD (cycle 35): valid ignored, so a core that deasserts one cycle late never retriggers. Earliest next accept is cycle 36.
- Valid dropping mid-operation is a protocol violation. The unit still completes and pulses ready. Operand changes after accept have no effect.
- Reset asserted mid-operation aborts immediately to IDLE, ready=0, rd=0, with no spurious pulse after release.
- DIV=0: divide datapath removed. Ops 1xx take the same path and produce 0.

Decomposition:
- Shared package/include (serv_mdu_defs): funct3 opcode localparams, FSM state encodings, ITER=32 constant.
- One sub-module, serv_mdu_core: 64-bit shift register plus 33-bit add/subtract iteration step, controlled by mul/div select and a step enable.
- Top level owns the FSM, counter, sign/special-case fixup and output gating.

Test Plan:
- MUL rs1=7, rs2=6, valid at cycle 0 -> ready high only in cycle 34, rd=0x0000002A; rd=0 in cycles 33 and 35 (ZERO_RD=1).
- High-half products, rs1=rs2=0xFFFFFFFF:
  - MULH -> 0x00000000
  - MULHSU -> 0xFFFFFFFF
  - MULHU -> 0xFFFFFFFE
- Signed divide rs1=0xFFFFFFF9 (-7), rs2=2:
  - DIV -> 0xFFFFFFFD
  - REM -> 0xFFFFFFFF
  - DIVU -> 0x7FFFFFFC
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF
  - REMU 5%0 -> 0x00000005
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
  - REM of the same operands -> 0x00000000
  - Each at cycle 34.
- i_rst_n low at cycle 10 of MUL 3*4 -> ready and rd 0 immediately, no pulse later; new MUL 3*4 accepted after release -> rd=0x0000000C exactly 34 cycles after accept.
- Valid held high through cycle 36 after MUL 2*2 -> one ready at cycle 34, GUARD ignores cycle 35, second accept at cycle 36, second ready at cycle 70.

Source files
------------

// File: rtl/serv_mdu_iter_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 opcodes, FSM state encoding, iteration count and negate helpers.
package serv_mdu_iter_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   // One radix-2 iteration per operand bit
   localparam int ITER = 32;
   localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CALC  = 3'd1,
      ST_FIX   = 3'd2,
      ST_RESP  = 3'd3,
      ST_GUARD = 3'd4
   } state_t;

   // Two's complement negate of a 32-bit value
   function automatic logic [31:0] neg32(input logic [31:0] x);
      return ~x + 32'd1;
   endfunction

   // Two's complement negate of a 64-bit value
   function automatic logic [63:0] neg64(input logic [63:0] x);
      return ~x + 64'd1;
   endfunction

endpackage

// File: rtl/serv_mdu_iter_core.sv
// Radix-2 iteration datapath: 64-bit shift register {hi, lo} plus one shared
// 33-bit add/subtract step. Multiply is shift-add on unsigned magnitudes
// (lo starts as the multiplicand); divide is restoring division on unsigned
// magnitudes (lo starts as the dividend and collects quotient bits, hi is the
// partial remainder).
module serv_mdu_iter_core (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   input  logic        is_div,
   input  logic [31:0] a_mag,
   input  logic [31:0] b_mag,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   logic [31:0] hi_r;
   logic [31:0] lo_r;
   logic [31:0] b_r;

   logic [32:0] shifted_s;
   logic [33:0] add_a_s;
   logic [33:0] add_res_s;
   logic [32:0] mul_sum_s;
   logic        ge_s;
   logic [31:0] hi_nxt_s;
   logic [31:0] lo_nxt_s;

   // One iteration step: shared adder, then mul or div shift/restore
   always_comb begin
      shifted_s = {hi_r, lo_r[31]};
      mul_sum_s = 33'd0;
      ge_s      = 1'b0;
      hi_nxt_s  = hi_r;
      lo_nxt_s  = lo_r;
      if (is_div) begin
         add_a_s   = {1'b0, shifted_s};
         add_res_s = add_a_s - {2'b00, b_r};
      end else begin
         add_a_s   = {2'b00, hi_r};
         add_res_s = add_a_s + {2'b00, b_r};
      end
      if (is_div) begin
         // Non-negative difference means the divisor fits: keep it, quotient bit 1
         ge_s = ~add_res_s[33];
         if (ge_s) begin
            hi_nxt_s = add_res_s[31:0];
         end else begin
            hi_nxt_s = shifted_s[31:0];
         end
         lo_nxt_s = {lo_r[30:0], ge_s};
      end else begin
         if (lo_r[0]) begin
            mul_sum_s = add_res_s[32:0];
         end else begin
            mul_sum_s = {1'b0, hi_r};
         end
         hi_nxt_s = mul_sum_s[32:1];
         lo_nxt_s = {mul_sum_s[0], lo_r[31:1]};
      end
   end

   // Shift register: load magnitudes on accept, advance one step per enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_r <= 32'd0;
         lo_r <= 32'd0;
         b_r  <= 32'd0;
      end else if (load) begin
         hi_r <= 32'd0;
         lo_r <= a_mag;
         b_r  <= b_mag;
      end else if (step) begin
         hi_r <= hi_nxt_s;
         lo_r <= lo_nxt_s;
      end else begin
         hi_r <= hi_r;
         lo_r <= lo_r;
      end
   end

   assign hi = hi_r;
   assign lo = lo_r;

endmodule

// File: rtl/serv_mdu_iter.sv
// Iterative RV32M multiply/divide unit on the CPU extension interface.
// Fixed latency for every op: accept, 32 iterations, one fixup cycle, one
// ready cycle, one guard cycle that ignores a late-dropping valid.
module serv_mdu_iter
   import serv_mdu_iter_pkg::*;
#(
   parameter int DIV     = 1,
   parameter int ZERO_RD = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_mdu_valid,
   input  logic [31:0] i_mdu_rs1,
   input  logic [31:0] i_mdu_rs2,
   input  logic [2:0]  i_mdu_op,
   output logic [31:0] o_mdu_rd,
   output logic        o_mdu_ready
);

   state_t      state_r;
   state_t      state_nxt_s;
   logic [4:0]  cnt_r;

   logic        load_s;
   logic        step_s;
   logic        fix_s;

   logic        rs1_signed_s;
   logic        rs2_signed_s;
   logic        neg_a_s;
   logic        neg_b_s;
   logic [31:0] a_mag_s;
   logic [31:0] b_mag_s;

   logic [2:0]  op_r;
   logic        neg_a_r;
   logic        neg_b_r;
   logic        zero_r;
   logic        ovf_r;

   logic        is_div_s;
   logic [31:0] hi_s;
   logic [31:0] lo_s;

   logic [63:0] prod_s;
   logic [31:0] mul_res_s;
   logic [31:0] quo_s;
   logic [31:0] rem_s;
   logic [31:0] div_res_s;
   logic [31:0] result_s;

   logic        ready_r;
   logic [31:0] rd_r;

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; GUARD never looks at valid
   always_comb begin
      state_nxt_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (i_mdu_valid) begin
               state_nxt_s = ST_CALC;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (cnt_r == CNT_LAST) begin
               state_nxt_s = ST_FIX;
            end else begin
               state_nxt_s = ST_CALC;
            end
         end
         ST_FIX:   state_nxt_s = ST_RESP;
         ST_RESP:  state_nxt_s = ST_GUARD;
         ST_GUARD: state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM control outputs
   always_comb begin
      load_s = 1'b0;
      step_s = 1'b0;
      fix_s  = 1'b0;
      case (state_r)
         ST_IDLE:  load_s = i_mdu_valid;
         ST_CALC:  step_s = 1'b1;
         ST_FIX:   fix_s  = 1'b1;
         ST_RESP:  load_s = 1'b0;
         ST_GUARD: load_s = 1'b0;
         default:  load_s = 1'b0;
      endcase
   end

   // Iteration counter: cleared on accept, wraps 31->0 on the last step
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_r <= 5'd0;
      end else if (load_s) begin
         cnt_r <= 5'd0;
      end else if (step_s) begin
         cnt_r <= cnt_r + 5'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Operand signedness per funct3
   always_comb begin
      rs1_signed_s = 1'b0;
      rs2_signed_s = 1'b0;
      case (i_mdu_op)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            rs1_signed_s = 1'b1;
            rs2_signed_s = 1'b1;
         end
         OP_MULHSU: begin
            rs1_signed_s = 1'b1;
            rs2_signed_s = 1'b0;
         end
         OP_MULHU, OP_DIVU, OP_REMU: begin
            rs1_signed_s = 1'b0;
            rs2_signed_s = 1'b0;
         end
         default: begin
            rs1_signed_s = 1'b0;
            rs2_signed_s = 1'b0;
         end
      endcase
   end

   assign neg_a_s = rs1_signed_s & i_mdu_rs1[31];
   assign neg_b_s = rs2_signed_s & i_mdu_rs2[31];
   assign a_mag_s = neg_a_s ? neg32(i_mdu_rs1) : i_mdu_rs1;
   assign b_mag_s = neg_b_s ? neg32(i_mdu_rs2) : i_mdu_rs2;

   // Request latch: op, sign flags and special-case flags captured at accept
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_r    <= 3'd0;
         neg_a_r <= 1'b0;
         neg_b_r <= 1'b0;
         zero_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else if (load_s) begin
         op_r    <= i_mdu_op;
         neg_a_r <= neg_a_s;
         neg_b_r <= neg_b_s;
         zero_r  <= (i_mdu_rs2 == 32'd0);
         ovf_r   <= (i_mdu_rs1 == 32'h8000_0000) && (i_mdu_rs2 == 32'hFFFF_FFFF) &&
                    ((i_mdu_op == OP_DIV) || (i_mdu_op == OP_REM));
      end else begin
         op_r    <= op_r;
         neg_a_r <= neg_a_r;
         neg_b_r <= neg_b_r;
         zero_r  <= zero_r;
         ovf_r   <= ovf_r;
      end
   end

   assign is_div_s = (DIV != 0) && op_r[2];

   serv_mdu_iter_core u_core (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .load   (load_s),
      .step   (step_s),
      .is_div (is_div_s),
      .a_mag  (a_mag_s),
      .b_mag  (b_mag_s),
      .hi     (hi_s),
      .lo     (lo_s)
   );

   // Sign correction and divide special cases. A zero divisor leaves the
   // dividend magnitude in hi, so the sign-corrected remainder is rs1 already.
   always_comb begin
      prod_s = {hi_s, lo_s};
      if (neg_a_r ^ neg_b_r) begin
         prod_s = neg64({hi_s, lo_s});
      end else begin
         prod_s = {hi_s, lo_s};
      end
      if (op_r == OP_MUL) begin
         mul_res_s = prod_s[31:0];
      end else begin
         mul_res_s = prod_s[63:32];
      end

      if (neg_a_r ^ neg_b_r) begin
         quo_s = neg32(lo_s);
      end else begin
         quo_s = lo_s;
      end
      if (neg_a_r) begin
         rem_s = neg32(hi_s);
      end else begin
         rem_s = hi_s;
      end
      if (zero_r) begin
         quo_s = 32'hFFFF_FFFF;
      end else if (ovf_r) begin
         quo_s = 32'h8000_0000;
         rem_s = 32'd0;
      end else begin
         quo_s = quo_s;
      end

      if (op_r[1]) begin
         div_res_s = rem_s;
      end else begin
         div_res_s = quo_s;
      end

      if (!op_r[2]) begin
         result_s = mul_res_s;
      end else if (DIV != 0) begin
         result_s = div_res_s;
      end else begin
         result_s = 32'd0;
      end
   end

   // Registered response: one-cycle ready pulse with result, rd gated when idle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ready_r <= 1'b0;
         rd_r    <= 32'd0;
      end else if (fix_s) begin
         ready_r <= 1'b1;
         rd_r    <= result_s;
      end else if (ZERO_RD != 0) begin
         ready_r <= 1'b0;
         rd_r    <= 32'd0;
      end else begin
         ready_r <= 1'b0;
         rd_r    <= rd_r;
      end
   end

   assign o_mdu_ready = ready_r;
   assign o_mdu_rd    = rd_r;

endmodule
